aes_op_sched: RTL and testbench



---
 rtl/aes_sched_pkg.sv | 25 ++
 rtl/aes_rr_arb2.sv | 35 +++
 rtl/aes_op_sched.sv | 151 +++++++++++++++
 tb/tb_aes_op_sched.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared encodings for the AES operation scheduler: FSM states, operation codes,
// requester ids and the default core latency.
package aes_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Start pulse to final-round cycle (KEY_PREPARE through TENTH_ROUND).
    localparam int CORE_LAT_DEFAULT = 12;

    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// Combinational two-way grant for the AES scheduler. Round robin on last_grant by
// default; fixed priority to requester 0 when AES_SCHED_PRIO_EN is defined.
module aes_rr_arb2
    import aes_sched_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic enable,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (enable) begin
`ifdef AES_SCHED_PRIO_EN
            gnt0 = valid0;
            gnt1 = valid1 & ~valid0;
`else
            if (valid0 && valid1) begin
                // Tie goes to whichever requester was not served last.
                gnt0 = (other_req(last_grant) == REQ0);
                gnt1 = (other_req(last_grant) == REQ1);
            end else begin
                gnt0 = valid0;
                gnt1 = valid1;
            end
`endif
        end
    end

endmodule

// File: rtl/aes_op_sched.sv
// Two-requester scheduler sharing one AES round core: accept, start pulse, round
// timing, capture strobe and tagged response. AES_SCHED_PRIO_EN selects fixed priority.
module aes_op_sched
    import aes_sched_pkg::*;
#(
    parameter int CORE_LAT = CORE_LAT_DEFAULT,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0_valid,
    input  logic req0_op,
    output logic req0_ready,
    input  logic req1_valid,
    input  logic req1_op,
    output logic req1_ready,
    output logic staenc,
    output logic stadec,
    output logic cap_en,
    output logic busy,
    output logic rsp_valid,
    output logic rsp_id,
    output logic rsp_op,
    input  logic rsp_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CORE_LAT - 2);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic             op_q, op_d;
    logic             staenc_q, staenc_d;
    logic             stadec_q, stadec_d;
    logic             cap_en_q, cap_en_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_op_q, rsp_op_d;

    logic arb_en;
    logic gnt0, gnt1;

    // Ready must stay low while reset is asserted, even though state_q is IDLE.
    assign arb_en = (state_q == IDLE) && !rst;

    aes_rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .enable     (arb_en),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        staenc_d     = 1'b0;
        stadec_d     = 1'b0;
        cap_en_d     = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_op_d     = rsp_op_q;

        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    id_d         = gnt1 ? REQ1 : REQ0;
                    op_d         = gnt1 ? req1_op : req0_op;
                    last_grant_d = id_d;
                    staenc_d     = (op_d == OP_ENC);
                    stadec_d     = (op_d == OP_DEC);
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // cap_en is registered, so it is raised one count early to land on CNT_LAST.
                cap_en_d = (cnt_q == CNT_PRE);
                if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_op_d    = op_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample together.
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= REQ1;
            id_q         <= REQ0;
            op_q         <= OP_ENC;
            staenc_q     <= 1'b0;
            stadec_q     <= 1'b0;
            cap_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_op_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            staenc_q     <= staenc_d;
            stadec_q     <= stadec_d;
            cap_en_q     <= cap_en_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_op_q     <= rsp_op_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign staenc     = staenc_q;
    assign stadec     = stadec_q;
    assign cap_en     = cap_en_q;
    assign busy       = busy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_op     = rsp_op_q;

endmodule

// File: tb/tb_aes_op_sched.sv
// Self-checking bench for aes_op_sched: a cycle-timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_aes_op_sched;
    import aes_sched_pkg::*;

    localparam int LAT = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req0_op = 1'b0;
    logic req1_valid = 1'b0, req1_op = 1'b0;
    logic rsp_ready = 1'b0;
    logic req0_ready, req1_ready, staenc, stadec, cap_en, busy;
    logic rsp_valid, rsp_id, rsp_op;

    int total = 0;
    int bad   = 0;
    bit mdl_on = 1'b0;

    always #5 clk = ~clk;

    aes_op_sched #(.CORE_LAT(LAT), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .staenc     (staenc),
        .stadec     (stadec),
        .cap_en     (cap_en),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_op     (rsp_op),
        .rsp_ready  (rsp_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Timeline model: an accepted operation at cycle a owns the core until its response
    // is taken; outputs follow from the cycle offset relative to a.
    initial begin : model
        bit act, m_id, m_op, last_g, e_r0, e_r1;
        int acc, cyc, rel;
        act = 1'b0; last_g = 1'b1; cyc = 0; acc = 0;
        wait (mdl_on);
        forever begin
            smp();
            rel  = cyc - acc;
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (!act && !rst) begin
`ifdef AES_SCHED_PRIO_EN
                e_r0 = req0_valid;
                e_r1 = req1_valid && !req0_valid;
`else
                if (req0_valid && req1_valid) begin
                    e_r0 = last_g;
                    e_r1 = !last_g;
                end else begin
                    e_r0 = req0_valid;
                    e_r1 = req1_valid;
                end
`endif
            end
            check($sformatf("m_rdy0@%0d", cyc), req0_ready, e_r0);
            check($sformatf("m_rdy1@%0d", cyc), req1_ready, e_r1);
            check($sformatf("m_excl_rdy@%0d", cyc), req0_ready && req1_ready, 0);
            check($sformatf("m_staenc@%0d", cyc), staenc, act && rel == 1 && !m_op);
            check($sformatf("m_stadec@%0d", cyc), stadec, act && rel == 1 && m_op);
            check($sformatf("m_cap@%0d", cyc), cap_en, act && rel == LAT + 1);
            check($sformatf("m_busy@%0d", cyc), busy, act);
            check($sformatf("m_rspv@%0d", cyc), rsp_valid, act && rel >= LAT + 2);
            if (act && rel >= LAT + 2) begin
                check($sformatf("m_rspid@%0d", cyc), rsp_id, m_id);
                check($sformatf("m_rspop@%0d", cyc), rsp_op, m_op);
            end
            if (rst) begin
                act    = 1'b0;
                last_g = 1'b1;
            end else if (act) begin
                if (rel >= LAT + 2 && rsp_ready) act = 1'b0;
            end else if (e_r0 || e_r1) begin
                act    = 1'b1;
                acc    = cyc;
                m_id   = e_r1;
                m_op   = e_r1 ? req1_op : req0_op;
                last_g = m_id;
            end
            cyc++;
        end
    end

    // One operation from requester id; the other requester raises valid for offsets
    // [ov_from, ov_to]. Response is held off for hold cycles.
    task automatic single_txn(input bit id, input bit op, input int hold,
                              input int ov_from, input int ov_to);
        bit oth;
        int post;
        rsp_ready = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req0_valid = 1'b0; req0_op = ~op;
        end else begin
            req0_valid = 1'b1; req0_op = op; req1_valid = 1'b0; req1_op = ~op;
        end
        smp();
        check("t_acc_rdy", id ? req1_ready : req0_ready, 1);
        step();
        for (int k = 1; k <= LAT + 2 + hold; k++) begin
            oth = (k >= ov_from) && (k <= ov_to);
            if (id) begin req1_valid = 1'b0; req0_valid = oth; end
            else    begin req0_valid = 1'b0; req1_valid = oth; end
            rsp_ready = (k == LAT + 2 + hold);
            smp();
            check($sformatf("t_staenc k=%0d", k), staenc, (k == 1) && (op == OP_ENC));
            check($sformatf("t_stadec k=%0d", k), stadec, (k == 1) && (op == OP_DEC));
            check($sformatf("t_cap k=%0d", k), cap_en, k == LAT + 1);
            check($sformatf("t_rspv k=%0d", k), rsp_valid, k >= LAT + 2);
            check($sformatf("t_oth_rdy k=%0d", k), id ? req0_ready : req1_ready, 0);
            if (k >= LAT + 2) begin
                check($sformatf("t_rspid k=%0d", k), rsp_id, id);
                check($sformatf("t_rspop k=%0d", k), rsp_op, op);
            end
            step();
        end
        post = LAT + 3 + hold;
        oth  = (post >= ov_from) && (post <= ov_to);
        if (id) begin req1_valid = 1'b0; req0_valid = oth; end
        else    begin req0_valid = 1'b0; req1_valid = oth; end
        rsp_ready = 1'b0;
        smp();
        check("t_post_rspv", rsp_valid, 0);
        check("t_post_busy", busy, 0);
        check("t_post_oth_rdy", id ? req0_ready : req1_ready, oth);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        smp();
        while (busy && n < bound) begin
            step();
            smp();
            n++;
        end
        check("idle_wait", busy, 0);
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin : stim
        int g_cyc[$];
        bit g_id[$];
        bit exp_id;

        // Reset cycle: valid is offered but ready must stay low.
        step();
        mdl_on = 1'b1;
        req0_valid = 1'b1;
        smp();
        check("rst_rdy0", req0_ready, 0);
        check("rst_staenc", staenc, 0);
        check("rst_stadec", stadec, 0);
        check("rst_cap", cap_en, 0);
        check("rst_busy", busy, 0);
        check("rst_rspv", rsp_valid, 0);
        check("rst_rspid", rsp_id, 0);
        check("rst_rspop", rsp_op, 0);
        step();
        rst = 1'b0;

        // Basic encrypt from requester 0.
        single_txn(REQ0, OP_ENC, 3, 0, -1);

        // Both requesters valid continuously, response always accepted.
        req0_valid = 1'b1; req0_op = OP_DEC;
        req1_valid = 1'b1; req1_op = OP_ENC;
        rsp_ready  = 1'b1;
        for (int c = 0; c < 64; c++) begin
            smp();
            if (req0_ready || req1_ready) begin
                g_cyc.push_back(c);
                g_id.push_back(req1_ready);
            end
`ifdef AES_SCHED_PRIO_EN
            check($sformatf("prio_rdy1 c=%0d", c), req1_ready, 0);
`endif
            step();
        end
        wait_idle(40);
        check("arb_count", g_cyc.size(), 5);
        for (int i = 0; i < g_id.size(); i++) begin
`ifdef AES_SCHED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (i % 2 == 0);
`endif
            check($sformatf("arb_id %0d", i), g_id[i], exp_id);
            if (i > 0) check($sformatf("arb_gap %0d", i), g_cyc[i] - g_cyc[i-1], 15);
        end

        // Requester 1 shows valid only while the core is running: never served.
        single_txn(REQ0, OP_ENC, 0, 4, 9);
        repeat (3) begin
            smp();
            check("drop_rdy1", req1_ready, 0);
            check("drop_staenc", staenc, 0);
            check("drop_stadec", stadec, 0);
            step();
        end

        // Response back-pressured for 5 cycles with requester 1 waiting throughout.
        single_txn(REQ0, OP_ENC, 5, 1, 99);
        wait_idle(40);

        // Reset while running at cnt = 6.
        req0_valid = 1'b1; req0_op = OP_DEC;
        smp();
        check("rr_acc", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            smp();
            step();
        end
        rst = 1'b1;
        smp();
        check("rr_busy_before", busy, 1);
        step();
        rst = 1'b0;
        smp();
        check("rr_staenc", staenc, 0);
        check("rr_stadec", stadec, 0);
        check("rr_cap", cap_en, 0);
        check("rr_busy", busy, 0);
        check("rr_rspv", rsp_valid, 0);
        check("rr_rspid", rsp_id, 0);
        check("rr_rspop", rsp_op, 0);
        step();
        for (int k = 0; k < 20; k++) begin
            smp();
            check($sformatf("rr_nocap k=%0d", k), cap_en, 0);
            check($sformatf("rr_norsp k=%0d", k), rsp_valid, 0);
            step();
        end

        // Served normally after the reset.
        single_txn(REQ1, OP_DEC, 0, 0, -1);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
